// File: rtl/xpe_wb.sv
// ---------------------------------------------------------------------------
// xpe_wb : XPE write-back stage.
//
// Collects 256-bit result beats from the XPE stage (which cannot be stalled)
// into a small show-ahead skid FIFO and writes them to the output RAM at
// base, base+stride, base+2*stride, ... (modulo 2^ADDR_WIDTH), whenever the
// RAM arbiter grants. A beat arriving while the FIFO is full and not being
// drained is dropped and the sticky overflow flag is raised. The dropped beat
// still counts toward completion, so a job always terminates.
//
// Parameters
//   ADDR_WIDTH  output RAM word address width
//   FIFO_DEPTH  skid FIFO entries (power of 2, >= 2)
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            one-cycle job start (honoured in IDLE only)
//   i_addr_start_o     first output word address
//   i_addr_stride      address increment per written word
//   i_total_num        number of beats in the job
//   i_xpe_dat/_vld     result beat and its qualifier
//   i_wr_ready         RAM arbiter grant
//   o_ram_we/_waddr/_wdata  write request, address and FIFO head data
//   o_busy             high while the job runs
//   o_done             one-cycle completion pulse
//   o_ovf              sticky overflow flag, cleared by the next start
// ---------------------------------------------------------------------------
module xpe_wb #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_start_o,
    input  logic [ADDR_WIDTH-1:0] i_addr_stride,
    input  logic [15:0]           i_total_num,
    input  logic [255:0]          i_xpe_dat,
    input  logic                  i_xpe_dat_vld,
    input  logic                  i_wr_ready,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_waddr,
    output logic [255:0]          o_ram_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [15:0]           total_q, total_d;
    logic [15:0]           accepted_q, accepted_d;
    logic [15:0]           written_q, written_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [255:0]          mem [FIFO_DEPTH];

    logic                  run;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  ram_we;
    logic                  pop;
    logic                  push_req;
    logic                  drop;
    logic                  push;
    logic [16:0]           written_nxt;

    always_comb begin
        run         = (state_q == ST_RUN);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
        ram_we      = run && !fifo_empty;
        pop         = ram_we && i_wr_ready;
        // Beats beyond the job length, or outside RUN, are silently ignored.
        push_req    = run && i_xpe_dat_vld && (accepted_q < total_q);
        // A full FIFO can still take a beat if the head leaves this cycle.
        drop        = push_req && fifo_full && !pop;
        push        = push_req && !drop;
        // Completion counts both real writes and dropped beats.
        written_nxt = 17'(written_q) + 17'(pop) + 17'(drop);
    end

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        stride_d   = stride_q;
        total_d    = total_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_RUN;
                    waddr_d    = i_addr_start_o;
                    stride_d   = i_addr_stride;
                    total_d    = i_total_num;
                    accepted_d = '0;
                    written_d  = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (push_req) begin
                    accepted_d = accepted_q + 16'd1;
                end
                if (pop) begin
                    waddr_d = waddr_q + stride_q;
                end
                if (drop) begin
                    ovf_d = 1'b1;
                end
                written_d = written_nxt[15:0];
                // Also covers a zero-length job: leaves RUN on its first cycle.
                if (written_nxt == {1'b0, total_q}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            waddr_q    <= '0;
            stride_q   <= '0;
            total_q    <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            stride_q   <= stride_d;
            total_q    <= total_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_xpe_dat;
        end
    end

    assign o_ram_we    = ram_we;
    assign o_ram_waddr = waddr_q;
    // Masked when empty so stale storage never shows (e.g. right after reset).
    assign o_ram_wdata = fifo_empty ? '0 : mem[rd_ptr_q];
    assign o_busy      = run;
    assign o_done      = (state_q == ST_DONE);
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_xpe_wb.sv
module tb_xpe_wb;

    localparam int AW = 12;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] i_addr_start_o;
    logic [AW-1:0] i_addr_stride;
    logic [15:0]   i_total_num;
    logic [255:0]  i_xpe_dat;
    logic          i_xpe_dat_vld;
    logic          i_wr_ready;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_waddr;
    logic [255:0]  o_ram_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_ovf;

    xpe_wb #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_addr_start_o(i_addr_start_o),
        .i_addr_stride (i_addr_stride),
        .i_total_num   (i_total_num),
        .i_xpe_dat     (i_xpe_dat),
        .i_xpe_dat_vld (i_xpe_dat_vld),
        .i_wr_ready    (i_wr_ready),
        .o_ram_we      (o_ram_we),
        .o_ram_waddr   (o_ram_waddr),
        .o_ram_wdata   (o_ram_wdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_ovf         (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Write / done log, sampled mid-cycle.
    logic [AW-1:0] wa_q[$];
    logic [255:0]  wd_q[$];
    int            wc_q[$];
    int            done_n   = 0;
    int            done_cyc = -1;

    always @(negedge i_clk) begin
        if (o_ram_we && i_wr_ready) begin
            wa_q.push_back(o_ram_waddr);
            wd_q.push_back(o_ram_wdata);
            wc_q.push_back(cyc);
        end
        if (o_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    typedef struct {
        logic          start;
        logic          vld;
        logic          rdy;
        int            didx;
        logic          ew;
        logic [AW-1:0] ea;
        int            edi;
        logic          eb;
        logic          ed;
        logic          eo;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [255:0] beat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [15:0] total, output int s);
        i_addr_start_o = base;
        i_addr_stride  = stride;
        i_total_num    = total;
        i_start        = 1'b1;
        s              = cyc;
        tick();
        i_start        = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = done_n;
        for (int i = 0; i < budget && done_n == n0; i++) tick();
        chk("done_within_budget", 256'(done_n != n0), 256'(1));
    endtask

    task automatic check_writes(input string nm, input int n, input logic [AW-1:0] base,
                                input logic [AW-1:0] stride, input int first);
        logic [AW-1:0] ea;
        chk({nm, "_count"}, 256'(wa_q.size()), 256'(n));
        ea = base;
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk({nm, "_addr"}, 256'(wa_q[i]), 256'(ea));
            chk({nm, "_data"}, wd_q[i], beat(first + i));
            ea = ea + stride;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // cycle-by-cycle basic job: base 0x010, stride 1, total 3
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 12'h000, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 12'h000, 0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 12'h010, 1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 12'h011, 2, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 12'h012, 3, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 12'h000, 0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 12'h000, 0, 1'b0, 1'b0, 1'b0};

        i_rst          = 1'b1;
        i_start        = 1'b0;
        i_addr_start_o = '0;
        i_addr_stride  = '0;
        i_total_num    = '0;
        i_xpe_dat      = '0;
        i_xpe_dat_vld  = 1'b0;
        i_wr_ready     = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_we",    256'(o_ram_we),    256'(0));
        chk("rst_waddr", 256'(o_ram_waddr), 256'(0));
        chk("rst_wdata", o_ram_wdata,       256'(0));
        chk("rst_busy",  256'(o_busy),      256'(0));
        chk("rst_done",  256'(o_done),      256'(0));
        chk("rst_ovf",   256'(o_ovf),       256'(0));
        i_rst = 1'b0;
        tick();

        // basic job from the table
        i_addr_start_o = 12'h010;
        i_addr_stride  = 12'h001;
        i_total_num    = 16'd3;
        for (int i = 0; i < 7; i++) begin
            i_start       = tbl[i].start;
            i_xpe_dat_vld = tbl[i].vld;
            i_xpe_dat     = beat(tbl[i].didx);
            i_wr_ready    = tbl[i].rdy;
            chk($sformatf("basic_c%0d_we", i),   256'(o_ram_we), 256'(tbl[i].ew));
            chk($sformatf("basic_c%0d_busy", i), 256'(o_busy),   256'(tbl[i].eb));
            chk($sformatf("basic_c%0d_done", i), 256'(o_done),   256'(tbl[i].ed));
            chk($sformatf("basic_c%0d_ovf", i),  256'(o_ovf),    256'(tbl[i].eo));
            if (tbl[i].ew) begin
                chk($sformatf("basic_c%0d_addr", i), 256'(o_ram_waddr), 256'(tbl[i].ea));
                chk($sformatf("basic_c%0d_data", i), o_ram_wdata, beat(tbl[i].edi));
            end
            tick();
        end
        i_start       = 1'b0;
        i_xpe_dat_vld = 1'b0;

        // backpressure and overflow: 6 beats into a 4-deep FIFO with no grant
        clear_log();
        i_wr_ready = 1'b0;
        start_job(12'h100, 12'h002, 16'd6, s);
        for (int k = 0; k < 6; k++) begin
            i_xpe_dat_vld = 1'b1;
            i_xpe_dat     = beat(10 + k);
            tick();
        end
        i_xpe_dat_vld = 1'b0;
        chk("bp_ovf_set", 256'(o_ovf),    256'(1));
        chk("bp_we_held", 256'(o_ram_we), 256'(1));
        chk("bp_busy",    256'(o_busy),   256'(1));
        repeat (2) tick();
        chk("bp_addr_stable", 256'(o_ram_waddr), 256'(12'h100));
        chk("bp_data_stable", o_ram_wdata,       beat(10));
        i_wr_ready = 1'b1;
        wait_done(30);
        check_writes("bp", 4, 12'h100, 12'h002, 10);
        if (wc_q.size() == 4) chk("bp_done_after_last", 256'(done_cyc), 256'(wc_q[3] + 1));
        chk("bp_ovf_sticky", 256'(o_ovf), 256'(1));

        // full FIFO with simultaneous pop; a start while running is ignored
        clear_log();
        i_wr_ready = 1'b0;
        start_job(12'h200, 12'h001, 16'd8, s);
        chk("fp_ovf_cleared", 256'(o_ovf), 256'(0));
        for (int k = 0; k < 8; k++) begin
            i_xpe_dat_vld = 1'b1;
            i_xpe_dat     = beat(20 + k);
            i_wr_ready    = (k >= 4);
            if (k == 5) begin
                i_start        = 1'b1;
                i_addr_start_o = 12'h7AA;
            end
            tick();
            i_start = 1'b0;
        end
        i_xpe_dat_vld = 1'b0;
        i_wr_ready    = 1'b1;
        wait_done(30);
        check_writes("fp", 8, 12'h200, 12'h001, 20);
        chk("fp_ovf", 256'(o_ovf), 256'(0));

        // address wrap
        clear_log();
        start_job(12'hFFE, 12'h001, 16'd4, s);
        for (int k = 0; k < 4; k++) begin
            i_xpe_dat_vld = 1'b1;
            i_xpe_dat     = beat(30 + k);
            tick();
        end
        i_xpe_dat_vld = 1'b0;
        wait_done(20);
        check_writes("wrap", 4, 12'hFFE, 12'h001, 30);
        if (wa_q.size() == 4) chk("wrap_third_addr", 256'(wa_q[2]), 256'(12'h000));

        // vld in IDLE is discarded; zero-length job completes with no writes
        clear_log();
        i_xpe_dat_vld = 1'b1;
        i_xpe_dat     = beat(99);
        repeat (2) tick();
        chk("idle_vld_ovf", 256'(o_ovf), 256'(0));
        start_job(12'h050, 12'h001, 16'd0, s);
        wait_done(10);
        i_xpe_dat_vld = 1'b0;
        chk("zero_done_cycle", 256'(done_cyc), 256'(s + 2));
        chk("zero_no_writes", 256'(wa_q.size()), 256'(0));
        chk("zero_ovf", 256'(o_ovf), 256'(0));

        // abort with two entries queued, then a clean job
        clear_log();
        i_wr_ready = 1'b0;
        start_job(12'h300, 12'h001, 16'd5, s);
        for (int k = 0; k < 2; k++) begin
            i_xpe_dat_vld = 1'b1;
            i_xpe_dat     = beat(40 + k);
            tick();
        end
        i_xpe_dat_vld = 1'b0;
        chk("abort_we_before", 256'(o_ram_we), 256'(1));
        #2;
        i_rst = 1'b1;
        #1;
        chk("abort_we",    256'(o_ram_we),    256'(0));
        chk("abort_busy",  256'(o_busy),      256'(0));
        chk("abort_waddr", 256'(o_ram_waddr), 256'(0));
        chk("abort_wdata", o_ram_wdata,       256'(0));
        #2;
        i_rst = 1'b0;
        tick();
        clear_log();
        i_wr_ready = 1'b1;
        start_job(12'h020, 12'h003, 16'd2, s);
        for (int k = 0; k < 2; k++) begin
            i_xpe_dat_vld = 1'b1;
            i_xpe_dat     = beat(50 + k);
            tick();
        end
        i_xpe_dat_vld = 1'b0;
        wait_done(20);
        check_writes("post_abort", 2, 12'h020, 12'h003, 50);
        chk("post_abort_ovf", 256'(o_ovf), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpe_wb.md
XPE_WB -- requirements
Module: xpe_wb

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the output RAM word address width.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the number of 256-bit skid FIFO entries; it shall be a power of 2 and at least 2.
REQ-003 i_clk  in  1  is the single clock; all state shall update on its rising edge.
REQ-004 i_rst  in  1  is an asynchronous, active-high reset.
REQ-005 i_start  in  1  is a one-cycle job start pulse.
REQ-006 i_addr_start_o  in  ADDR_WIDTH  is the first output word address.
REQ-007 i_addr_stride  in  ADDR_WIDTH  is the address increment per written word.
REQ-008 i_total_num  in  16  is the number of 256-bit beats in the job.
REQ-009 i_xpe_dat  in  256  carries 32x8b results from the XPE stage.
REQ-010 i_xpe_dat_vld  in  1  qualifies i_xpe_dat; the XPE stage has no stall input.
REQ-011 i_wr_ready  in  1  is the output RAM arbiter grant.
REQ-012 o_ram_we  out  1  is the write request, i.e. the FIFO-not-empty indication while busy.
REQ-013 o_ram_waddr  out  ADDR_WIDTH  is the write address.
REQ-014 o_ram_wdata  out  256  is the FIFO head data.
REQ-015 o_busy  out  1  is high from the cycle after i_start until the done cycle.
REQ-016 o_done  out  1  is a one-cycle pulse on job completion.
REQ-017 o_ovf  out  1  is a sticky overflow flag.

Function
REQ-018 The FSM shall have three states: IDLE, RUN, DONE. The transitions are:
- IDLE to RUN on i_start.
- RUN to DONE in the cycle the last of i_total_num writes transfers.
- DONE to IDLE after exactly one cycle.
REQ-019 On i_start in IDLE, the block shall latch the base address, stride and beat count, clear the accepted/written counters, and clear o_ovf.
REQ-020 i_start while not in IDLE shall be ignored.
REQ-021 If the latched i_total_num is 0, the FSM shall go RUN to DONE on the next cycle with no writes.
REQ-022 Push: in RUN with accepted < total, each i_xpe_dat_vld cycle shall push i_xpe_dat and increment accepted.
REQ-023 vld in IDLE/DONE, or with accepted == total, shall be discarded without setting o_ovf.
REQ-024 A push when the FIFO is full with no simultaneous pop shall drop the beat, set o_ovf, and still increment accepted.
REQ-025 A push when the FIFO is full with a simultaneous pop shall be accepted.
REQ-026 The FIFO shall be show-ahead; a beat pushed at cycle N into an empty FIFO shall appear on o_ram_wdata with o_ram_we=1 at cycle N+1.
REQ-027 A transfer shall occur when o_ram_we && i_wr_ready; it pops one entry, increments written, and advances o_ram_waddr by the stride modulo 2^ADDR_WIDTH (wrap-around, no error).
REQ-028 While o_ram_we=1 and i_wr_ready=0, o_ram_wdata and o_ram_waddr shall hold stable.
REQ-029 Dropped beats shall count toward written completion (the written counter advances by the drop) so the job always terminates.
REQ-030 o_done shall be high exactly in the DONE cycle; o_busy shall be high in RUN only.
REQ-031 Beat order out shall equal beat order in; no reordering.
REQ-032 o_ram_we shall be 0 in IDLE and DONE.

Reset
REQ-033 On i_rst assertion (asynchronous, including mid-job), the block shall clear the FSM to IDLE, empty the FIFO, and clear all counters.
REQ-034 On i_rst, outputs shall be o_ram_we=0, o_ram_waddr=0, o_ram_wdata=0, o_busy=0, o_done=0, o_ovf=0.
REQ-035 The first i_start after i_rst deassertion shall be honoured.

Verification
REQ-036 Basic job: start with base=0x010, stride=1, total=3; 3 consecutive vld beats; i_wr_ready=1 -> we at addresses 0x010/0x011/0x012 in cycles N+1..N+3, data in order, o_done one cycle later, o_ovf=0.
REQ-037 Backpressure and overflow (DEPTH=4): i_wr_ready=0 with 6 vld beats, then i_wr_ready=1 -> beats 1-4 written, beats 5-6 dropped, o_ovf=1, o_done after the 4th write.
REQ-038 Full with simultaneous pop: FIFO full and i_wr_ready=1 while vld continues for 8 beats -> all 8 written, o_ovf=0.
REQ-039 Address wrap: ADDR_WIDTH=12, base=0xFFE, stride=1, total=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-040 Zero and abort:
- total=0 -> o_done two cycles after i_start with no writes.
- i_rst pulsed mid-job with 2 entries queued -> o_ram_we=0 immediately, and a subsequent job runs cleanly.
